// File: rtl/gcn_pkg.sv
// Shared types for the GCN layer scheduler.
//   sched_state_t : scheduler FSM states
//   sched_err_t   : err_code encoding reported to the host
//   in_phase()    : true for states where an engine is actively running
package gcn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_RUN,
    S_SWAP,
    S_C_RUN,
    S_DONE,
    S_ERR
  } sched_state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_T_TIMEOUT = 2'b01,
    ERR_C_TIMEOUT = 2'b10,
    ERR_ABORT     = 2'b11
  } sched_err_t;

  function automatic logic in_phase(input sched_state_t s);
    return (s == S_T_RUN) || (s == S_C_RUN);
  endfunction

endpackage

// File: rtl/gcn_phase_watchdog.sv
// Per-phase cycle counter for the scheduler.
//   clk, reset : clock, async active-high reset
//   clear      : zero the count on the next edge (phase entry / outside a phase)
//   en         : an engine phase is running; count advances, expiry is qualified
//   count      : cycles elapsed in the current phase, saturates at TIMEOUT_CYCLES
//   expired    : this is the last permitted cycle of the phase
module gcn_phase_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CYC_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             expired
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          count <= '0;
    else if (clear)                                     count <= '0;
    else if (en && (count != CYC_W'(TIMEOUT_CYCLES)))   count <= count + 1'b1;
  end

  assign expired = en && (count == CYC_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gcn_layer_scheduler.sv
// Top-level sequencer for one GCN inference run. Per layer it runs the
// transformation engine, swaps product-memory ownership, runs the
// combination engine, then advances the layer. Adds watchdog/abort/error.
//   clk, reset            : clock, async active-high reset
//   start / abort         : host run request / abandon current run
//   trans_done, comb_done : sticky done levels from the two engines
//   trans_start/comb_start: one-cycle engine start pulses
//   trans_rst/comb_rst    : engine hold-in-reset
//   prod_mem_owner        : 0 = transformation writes, 1 = combination reads
//   layer_idx             : current layer
//   busy, done, error     : run status; err_code gives the failure cause
//   phase_cycles          : cycles elapsed in the current engine phase
module gcn_layer_scheduler
  import gcn_pkg::*;
#(
  parameter int NUM_LAYERS     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LAYER_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  parameter int CYC_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               trans_done,
  input  logic               comb_done,
  output logic               trans_start,
  output logic               trans_rst,
  output logic               comb_start,
  output logic               comb_rst,
  output logic               prod_mem_owner,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [CYC_W-1:0]   phase_cycles
);

  sched_state_t state, next_state;
  sched_err_t   next_err;
  logic         wd_clear, wd_expired, last_layer, idle_like;

  assign last_layer = (layer_idx == LAYER_W'(NUM_LAYERS - 1));
  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

  // Count restarts on every phase entry (including C_RUN -> T_RUN) and is
  // held at zero whenever no engine phase is running.
  assign wd_clear = !in_phase(next_state) || (next_state != state);

  gcn_phase_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CYC_W         (CYC_W)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .en     (in_phase(state)),
    .count  (phase_cycles),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // The start pulse register doubles as the "first phase cycle" marker:
  // a done level seen then is left over from before the engine restarted.
  always_comb begin
    next_state = state;
    next_err   = sched_err_t'(err_code);
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          next_state = S_T_RUN;
          next_err   = ERR_NONE;
        end
      end
      S_T_RUN: begin
        if (abort) begin
          next_state = S_ERR;
          next_err   = ERR_ABORT;
        end else if (trans_done && !trans_start) begin
          next_state = S_SWAP;
        end else if (wd_expired) begin
          next_state = S_ERR;
          next_err   = ERR_T_TIMEOUT;
        end
      end
      S_SWAP: begin
        if (abort) begin
          next_state = S_ERR;
          next_err   = ERR_ABORT;
        end else begin
          next_state = S_C_RUN;
        end
      end
      S_C_RUN: begin
        if (abort) begin
          next_state = S_ERR;
          next_err   = ERR_ABORT;
        end else if (comb_done && !comb_start) begin
          next_state = last_layer ? S_DONE : S_T_RUN;
        end else if (wd_expired) begin
          next_state = S_ERR;
          next_err   = ERR_C_TIMEOUT;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trans_start    <= 1'b0;
      comb_start     <= 1'b0;
      trans_rst      <= 1'b1;
      comb_rst       <= 1'b1;
      prod_mem_owner <= 1'b0;
      layer_idx      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'b00;
    end else begin
      trans_start    <= (next_state == S_T_RUN) && (state != S_T_RUN);
      comb_start     <= (next_state == S_C_RUN) && (state != S_C_RUN);
      trans_rst      <= (next_state != S_T_RUN);
      comb_rst       <= (next_state != S_C_RUN);
      prod_mem_owner <= (next_state == S_SWAP) || (next_state == S_C_RUN);
      busy           <= in_phase(next_state) || (next_state == S_SWAP);
      done           <= (next_state == S_DONE);
      error          <= (next_state == S_ERR);
      err_code       <= next_err;
      if (idle_like && start)
        layer_idx <= '0;
      else if ((state == S_C_RUN) && (next_state == S_T_RUN))
        layer_idx <= layer_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_gcn_layer_scheduler.sv
module tb_gcn_layer_scheduler;

  localparam int NL  = 2;
  localparam int TO  = 16;
  localparam int LW  = 1;
  localparam int CW  = 5;

  logic          clk, reset, start, abort, trans_done, comb_done;
  logic          trans_start, trans_rst, comb_start, comb_rst, prod_mem_owner;
  logic [LW-1:0] layer_idx;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [CW-1:0] phase_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  gcn_layer_scheduler #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .trans_done    (trans_done),
    .comb_done     (comb_done),
    .trans_start   (trans_start),
    .trans_rst     (trans_rst),
    .comb_start    (comb_start),
    .comb_rst      (comb_rst),
    .prod_mem_owner(prod_mem_owner),
    .layer_idx     (layer_idx),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .phase_cycles  (phase_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ph;
    reset = 1'b1; start = 1'b0; abort = 1'b0; trans_done = 1'b0; comb_done = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst trans_rst", trans_rst, 1);
    chk("rst comb_rst",  comb_rst,  1);
    chk("rst busy",      busy,      0);
    chk("rst owner",     prod_mem_owner, 0);
    chk("rst layer",     layer_idx, 0);
    chk("rst done_err",  {done, error, err_code}, 0);
    chk("rst phase",     phase_cycles, 0);
    reset = 1'b0;

    // normal two-layer run, c0..c22
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      if      (c >= 1  && c <= 5)  ph = c - 1;
      else if (c >= 7  && c <= 10) ph = c - 7;
      else if (c >= 11 && c <= 15) ph = c - 11;
      else if (c >= 17 && c <= 20) ph = c - 17;
      else                         ph = 0;
      chk($sformatf("run c%0d trans_start", c), trans_start, (c == 1 || c == 11));
      chk($sformatf("run c%0d comb_start", c),  comb_start,  (c == 7 || c == 17));
      chk($sformatf("run c%0d owner", c), prod_mem_owner,
          ((c >= 6 && c <= 10) || (c >= 16 && c <= 20)));
      chk($sformatf("run c%0d layer", c), layer_idx, (c >= 11));
      chk($sformatf("run c%0d done", c),  done, (c >= 21));
      chk($sformatf("run c%0d busy", c),  busy, (c >= 1 && c <= 20));
      chk($sformatf("run c%0d trans_rst", c), trans_rst,
          !((c >= 1 && c <= 5) || (c >= 11 && c <= 15)));
      chk($sformatf("run c%0d comb_rst", c), comb_rst,
          !((c >= 7 && c <= 10) || (c >= 17 && c <= 20)));
      chk($sformatf("run c%0d phase", c), phase_cycles, ph);
      chk($sformatf("run c%0d error", c), error, 0);
      start      = (c == 0);
      trans_done = (c == 5 || c == 6 || c == 15 || c == 16);
      comb_done  = (c == 10 || c == 11 || c == 20 || c == 21);
    end

    // restart from DONE with a stale trans_done, then let T_RUN time out
    start = 1'b1; trans_done = 1'b1; comb_done = 1'b0;
    @(negedge clk);
    chk("stale d1 trans_start", trans_start, 1);
    chk("stale d1 layer",       layer_idx, 0);
    chk("stale d1 done",        done, 0);
    start = 1'b0;
    @(negedge clk);
    chk("stale d2 busy",      busy, 1);
    chk("stale d2 owner",     prod_mem_owner, 0);
    chk("stale d2 trans_rst", trans_rst, 0);
    chk("stale d2 phase",     phase_cycles, 1);
    trans_done = 1'b0;
    repeat (14) @(negedge clk);
    chk("tmo d16 busy",  busy, 1);
    chk("tmo d16 phase", phase_cycles, 15);
    chk("tmo d16 error", error, 0);
    @(negedge clk);
    chk("tmo d17 error",     error, 1);
    chk("tmo d17 err_code",  err_code, 2'b01);
    chk("tmo d17 trans_rst", trans_rst, 1);
    chk("tmo d17 comb_rst",  comb_rst, 1);
    chk("tmo d17 busy",      busy, 0);
    chk("tmo d17 phase",     phase_cycles, 0);

    // restart from ERR; start while busy ignored; abort + comb_done together
    start = 1'b1;
    @(negedge clk);
    chk("rerr e1 trans_start", trans_start, 1);
    chk("rerr e1 error",       error, 0);
    chk("rerr e1 err_code",    err_code, 0);
    chk("rerr e1 layer",       layer_idx, 0);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("busy-start e3 trans_start", trans_start, 0);
    chk("busy-start e3 phase",       phase_cycles, 2);
    start = 1'b0; trans_done = 1'b1;
    @(negedge clk);
    chk("swap e4 owner", prod_mem_owner, 1);
    chk("swap e4 rsts",  {trans_rst, comb_rst}, 2'b11);
    trans_done = 1'b0;
    @(negedge clk);
    chk("crun e5 comb_start", comb_start, 1);
    chk("crun e5 comb_rst",   comb_rst, 0);
    @(negedge clk);
    comb_done = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abort e7 error",    error, 1);
    chk("abort e7 err_code", err_code, 2'b11);
    chk("abort e7 done",     done, 0);
    chk("abort e7 owner",    prod_mem_owner, 0);
    chk("abort e7 comb_rst", comb_rst, 1);
    comb_done = 1'b0; abort = 1'b0;

    // async reset mid-T_RUN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("areset pre busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("areset busy",      busy, 0);
    chk("areset trans_rst", trans_rst, 1);
    chk("areset comb_rst",  comb_rst, 1);
    chk("areset error",     error, 0);
    start = 1'b1;
    @(negedge clk);
    chk("areset start-ignored trans_start", trans_start, 0);
    chk("areset start-ignored busy",        busy, 0);
    reset = 1'b0; start = 1'b0;

    // start and abort together in IDLE: start wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("idle start+abort trans_start", trans_start, 1);
    chk("idle start+abort busy",        busy, 1);
    chk("idle start+abort error",       error, 0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("idle start+abort g2 busy", busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
